// File: rtl/periph_tx_handshake.sv
// Peripheral-to-CPU transmitter: small FIFO drained over a 4-phase send/ack handshake.
// ack is synchronized into clk1; the whole block runs on clk1.
module periph_tx_handshake #(
  parameter int unsigned DATA_W  = 3,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk1,
  input  logic              rst1,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic              send,
  output logic [DATA_W-1:0] dataOutput,
  input  logic              ack,
  output logic              busy,
  output logic [7:0]        words_sent,
  output logic              overflow,
  output logic              timeout_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StSend    = 2'd1;
  localparam logic [1:0] StRelease = 2'd2;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, full_d, empty_q, empty_d;
  logic              overflow_q, overflow_d;
  logic              ack_meta_q, ack_s_q;
  logic [1:0]        state_q, state_d;
  logic              send_q, send_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [7:0]        words_q, words_d;
  logic              to_err_q, to_err_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic              push, pop;

  // FSM: a pop happens only on the IDLE->SEND transition.
  always_comb begin
    state_d  = state_q;
    send_d   = send_q;
    data_d   = data_q;
    words_d  = words_q;
    to_err_d = to_err_q;
    tmr_d    = tmr_q;
    pop      = 1'b0;
    case (state_q)
      StIdle: begin
        // A still-high ack_s belongs to the previous transfer; never start on it.
        if (count_q != '0 && !ack_s_q) begin
          pop     = 1'b1;
          data_d  = mem_q[rd_ptr_q];
          send_d  = 1'b1;
          tmr_d   = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (ack_s_q) begin
          send_d  = 1'b0;
          words_d = words_q + 8'd1;
          state_d = StRelease;
        end else if (TIMEOUT != 0 && tmr_q == TW'(TIMEOUT - 1)) begin
          send_d   = 1'b0;
          to_err_d = 1'b1;
          state_d  = StRelease;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      StRelease: begin
        if (!ack_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FIFO bookkeeping; a write into a full FIFO is accepted only alongside a pop.
  always_comb begin
    push       = wr_en && ((count_q != CW'(DEPTH)) || pop);
    overflow_d = overflow_q | (wr_en & ~push);
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    full_d     = (count_d == CW'(DEPTH));
    empty_d    = (count_d == '0);
  end

  always_ff @(posedge clk1) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk1 or posedge rst1) begin
    if (rst1) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
      state_q    <= StIdle;
      send_q     <= 1'b0;
      data_q     <= '0;
      words_q    <= '0;
      to_err_q   <= 1'b0;
      tmr_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      ack_meta_q <= ack;
      ack_s_q    <= ack_meta_q;
      state_q    <= state_d;
      send_q     <= send_d;
      data_q     <= data_d;
      words_q    <= words_d;
      to_err_q   <= to_err_d;
      tmr_q      <= tmr_d;
    end
  end

  assign full        = full_q;
  assign empty       = empty_q;
  assign send        = send_q;
  assign dataOutput  = data_q;
  assign busy        = (state_q != StIdle);
  assign words_sent  = words_q;
  assign overflow    = overflow_q;
  assign timeout_err = to_err_q;

endmodule
